// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: FSM state encoding,
// LFSR seed/taps for the optional random extra latency, latency ceiling.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4 -> bit positions 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam int MAX_LATENCY = 15;

endpackage

// File: rtl/data_mem_responder_if.sv
// Single-outstanding memory request/response bundle between an initiator
// (master) and the memory responder (slave).
interface data_mem_responder_if;

    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );

endinterface

// File: rtl/data_mem_responder_lfsr.sv
// Free-running-on-demand 8-bit Fibonacci LFSR; steps once per advance pulse
// and restarts from the fixed seed on reset so the sequence is repeatable.
module mem_resp_lfsr
    import mem_resp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    output logic [7:0] value
);

    // Shift left, feedback is the XOR of the tapped bits
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= {value[6:0], ^(value & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised memory responder for a single-outstanding read/write
// protocol. One request is accepted in IDLE, held for LATENCY cycles, then
// committed (byte-masked write or registered read) with a one-cycle mem_resp.
// Optional macro DATA_MEM_RESPONDER_RAND_LAT_EN adds 0..3 LFSR-driven extra
// BUSY cycles per transaction.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 1
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_responder_if.slave bus
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int LAT_EFF = (LATENCY < 1) ? 1 :
                             ((LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY);
    localparam logic [4:0] LAT_BASE = 5'(LAT_EFF - 1);

    // Storage is zero at time 0 and deliberately untouched by rst
    logic [31:0] mem_array [DEPTH] = '{default: 32'h0};

    state_t                  state_reg;
    logic [4:0]              count_reg;
    logic                    write_reg;
    logic                    in_range_reg;
    logic [ADDR_WIDTH-1:0]   idx_reg;
    logic [3:0]              be_reg;
    logic [31:0]             wdata_reg;
    logic [31:0]             rdata_reg;
    logic                    resp_reg;

    // Live address decode, used only at acceptance
    logic [31:0]             offset;
    logic [31:0]             word_off;
    logic                    live_in_range;
    logic [ADDR_WIDTH-1:0]   live_idx;

    assign offset        = bus.mem_address - BASE_ADDR;
    assign word_off      = offset >> 2;
    assign live_in_range = (bus.mem_address >= BASE_ADDR) &&
                           ((word_off >> ADDR_WIDTH) == 32'h0);
    assign live_idx      = word_off[ADDR_WIDTH-1:0];

    logic       accept;
    logic [1:0] extra_wait;
    logic [4:0] load_count;

    assign accept     = (state_reg == IDLE) && (bus.mem_read || bus.mem_write);
    assign load_count = LAT_BASE + {3'b000, extra_wait};

`ifdef DATA_MEM_RESPONDER_RAND_LAT_EN
    logic [7:0] lfsr_value;
    logic       unused_lfsr_bits;

    mem_resp_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (accept),
        .value   (lfsr_value)
    );

    // Extra wait comes from the LFSR value seen at acceptance, before it steps
    assign extra_wait       = lfsr_value[1:0];
    assign unused_lfsr_bits = ^lfsr_value[7:2];
`else
    assign extra_wait = 2'b00;
`endif

    // With zero loaded count the commit happens on the accepting edge, so the
    // live inputs are used in IDLE and the latched copy afterwards.
    logic                  cur_write;
    logic                  cur_in_range;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [3:0]            cur_be;
    logic [31:0]           cur_wdata;
    logic                  commit;

    assign cur_write    = (state_reg == IDLE) ? bus.mem_write     : write_reg;
    assign cur_in_range = (state_reg == IDLE) ? live_in_range     : in_range_reg;
    assign cur_idx      = (state_reg == IDLE) ? live_idx          : idx_reg;
    assign cur_be       = (state_reg == IDLE) ? bus.mem_byte_enable : be_reg;
    assign cur_wdata    = (state_reg == IDLE) ? bus.mem_wdata     : wdata_reg;

    assign commit = (accept && (load_count == 5'd0)) ||
                    ((state_reg == BUSY) && (count_reg <= 5'd1));

    // Per-lane write strobes; a write with no enabled lanes still completes
    logic [3:0] lane_wr;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_wr[gi] = commit && cur_write && cur_in_range && cur_be[gi];
        end
    endgenerate

    // Byte-masked storage write on the edge entering RESP; reset drops it
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_wr[i]) begin
                    mem_array[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read data; writes and out-of-range reads return zero
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= 32'h0;
        end else if (commit) begin
            rdata_reg <= (cur_write || !cur_in_range) ? 32'h0 : mem_array[cur_idx];
        end
    end

    // Request FSM: accept and latch in IDLE, count down in BUSY, pulse in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            count_reg    <= 5'd0;
            resp_reg     <= 1'b0;
            write_reg    <= 1'b0;
            in_range_reg <= 1'b0;
            idx_reg      <= '0;
            be_reg       <= 4'h0;
            wdata_reg    <= 32'h0;
        end else begin
            resp_reg <= commit;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        write_reg    <= bus.mem_write;
                        in_range_reg <= live_in_range;
                        idx_reg      <= live_idx;
                        be_reg       <= bus.mem_byte_enable;
                        wdata_reg    <= bus.mem_wdata;
                        count_reg    <= load_count;
                        state_reg    <= (load_count == 5'd0) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    if (count_reg <= 5'd1) begin
                        count_reg <= 5'd0;
                        state_reg <= RESP;
                    end else begin
                        count_reg <= count_reg - 5'd1;
                    end
                end
                RESP: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.mem_rdata = rdata_reg;
    assign bus.mem_resp  = resp_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 1 / base 0 and
// LATENCY 4 / base 0x100), a time-scheduled transaction model, a per-cycle
// compare process, directed cases and randomized traffic.
module tb_data_mem_responder;

    localparam int          AW    = 10;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_0100;
    localparam int          LAT0  = 1;
    localparam int          LAT1  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();

    logic        drv_read  [2];
    logic        drv_write [2];
    logic [3:0]  drv_be    [2];
    logic [31:0] drv_addr  [2];
    logic [31:0] drv_wdata [2];
    logic        resp_w    [2];
    logic [31:0] rdata_w   [2];

    assign bus0.mem_read        = drv_read[0];
    assign bus0.mem_write       = drv_write[0];
    assign bus0.mem_byte_enable = drv_be[0];
    assign bus0.mem_address     = drv_addr[0];
    assign bus0.mem_wdata       = drv_wdata[0];
    assign bus1.mem_read        = drv_read[1];
    assign bus1.mem_write       = drv_write[1];
    assign bus1.mem_byte_enable = drv_be[1];
    assign bus1.mem_address     = drv_addr[1];
    assign bus1.mem_wdata       = drv_wdata[1];
    assign resp_w[0]  = bus0.mem_resp;
    assign rdata_w[0] = bus0.mem_rdata;
    assign resp_w[1]  = bus1.mem_resp;
    assign rdata_w[1] = bus1.mem_rdata;

    data_mem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE0), .LATENCY(LAT0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    data_mem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE1), .LATENCY(LAT1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 0) ? BASE0 : BASE1;
    endfunction

    // ---------------- behavioural model ----------------
    // Each instance: a request accepted at edge e completes on edge
    // e+LAT-1 (response visible in the following cycle); the next request
    // can be accepted no earlier than two edges after completion.
    logic [31:0] mdl_mem [2][1024];
    bit          pend     [2];
    int          commit_e [2];
    int          free_e   [2];
    bit          p_rd     [2];
    bit          p_wr     [2];
    logic [3:0]  p_be     [2];
    logic [31:0] p_addr   [2];
    logic [31:0] p_wdata  [2];
    bit          exp_resp [2];
    bit          exp_chk  [2];
    logic [31:0] exp_rdata[2];
    int          edge_n = 0;

    task automatic model_step(input int k);
        logic [31:0] a;
        logic [31:0] woff;
        bit          ok;
        int          idx;
        exp_resp[k] = 1'b0;
        if (rst) begin
            pend[k]      = 1'b0;
            free_e[k]    = edge_n + 1;
            exp_rdata[k] = 32'h0;
        end else begin
            if (!pend[k] && edge_n >= free_e[k] && (drv_read[k] || drv_write[k])) begin
                p_rd[k]     = drv_read[k];
                p_wr[k]     = drv_write[k];
                p_be[k]     = drv_be[k];
                p_addr[k]   = drv_addr[k];
                p_wdata[k]  = drv_wdata[k];
                commit_e[k] = edge_n + lat_of(k) - 1;
                pend[k]     = 1'b1;
            end
            if (pend[k] && edge_n == commit_e[k]) begin
                a    = p_addr[k] & 32'hFFFF_FFFC;
                woff = (a - base_of(k)) >> 2;
                ok   = (a >= base_of(k)) && (woff < 32'd1024);
                idx  = int'(woff[9:0]);
                if (p_wr[k]) begin
                    if (ok) begin
                        for (int b = 0; b < 4; b++) begin
                            if (p_be[k][b]) mdl_mem[k][idx][8*b +: 8] = p_wdata[k][8*b +: 8];
                        end
                    end
                    exp_rdata[k] = 32'h0;
                    exp_chk[k]   = p_rd[k];
                end else begin
                    exp_rdata[k] = ok ? mdl_mem[k][idx] : 32'h0;
                    exp_chk[k]   = 1'b1;
                end
                exp_resp[k] = 1'b1;
                pend[k]     = 1'b0;
                free_e[k]   = edge_n + 2;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 1024; w++) mdl_mem[k][w] = 32'h0;
            pend[k] = 1'b0; free_e[k] = 0; commit_e[k] = 0;
            exp_resp[k] = 1'b0; exp_chk[k] = 1'b0; exp_rdata[k] = 32'h0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) model_step(k);
            edge_n++;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int k = 0; k < 2; k++) begin
                    check32($sformatf("resp_dut%0d_edge%0d", k, edge_n),
                            {31'b0, resp_w[k]}, {31'b0, exp_resp[k]});
                    if (exp_resp[k] && exp_chk[k])
                        check32($sformatf("rdata_dut%0d_edge%0d", k, edge_n),
                                rdata_w[k], exp_rdata[k]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int k, input logic rd, input logic wr, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        drv_read[k]  = rd;
        drv_write[k] = wr;
        drv_be[k]    = be;
        drv_addr[k]  = addr;
        drv_wdata[k] = wdata;
    endtask

    task automatic idle(input int k, input int n);
        drv_read[k]  = 1'b0;
        drv_write[k] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts negedges from the drive point to the response; returns #1 after
    // the edge that ends the response cycle, with the request still driven.
    task automatic wait_resp(input int k, input bit scramble, output int waits,
                             output logic [31:0] rd);
        bit done;
        done  = 1'b0;
        waits = 0;
        rd    = 32'h0;
        while (!done) begin
            @(negedge clk);
            waits++;
            if (resp_w[k]) begin
                rd   = rdata_w[k];
                done = 1'b1;
            end else if (waits >= 60) begin
                checks++;
                errors++;
                $display("FAIL resp_timeout_dut%0d: got no mem_resp expected one within 60 cycles", k);
                done = 1'b1;
            end else if (scramble && waits == 2) begin
                drv_addr[k]  = $urandom;
                drv_wdata[k] = $urandom;
                drv_be[k]    = 4'($urandom_range(0, 15));
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr(input int k);
        int sel;
        sel = int'($urandom_range(0, 7));
        if (sel == 0) return base_of(k) + 32'h1000 + 32'($urandom_range(0, 255));
        if (sel == 1 && k == 1) return 32'($urandom_range(0, 255));
        return base_of(k) + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int          w;
        logic [31:0] d;
        int          op;
        int          gap;
        bit          scr;
        for (int k = 0; k < 2; k++) drive(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Reset for two edges, then idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check32($sformatf("reset_resp_dut%0d", k), {31'b0, resp_w[k]}, 32'h0);
            check32($sformatf("reset_rdata_dut%0d", k), rdata_w[k], 32'h0);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check32("idle_no_resp", {31'b0, resp_w[0] | resp_w[1]}, 32'h0);
        end
        @(posedge clk);
        #1;

        // LATENCY=1 full word write then read
        drive(0, 1'b0, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
        wait_resp(0, 1'b0, w, d);
        checkn("lat1_write_latency", w, 2);
        drive(0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        wait_resp(0, 1'b0, w, d);
        checkn("lat1_read_latency", w, 2);
        check32("read_deadbeef", d, 32'hDEADBEEF);

        // Single byte lane via unaligned address
        drive(0, 1'b0, 1'b1, 4'b0010, 32'h41, 32'h0000_5500);
        wait_resp(0, 1'b0, w, d);
        drive(0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        wait_resp(0, 1'b0, w, d);
        check32("byte_lane1", d, 32'hDEAD55EF);

        // Zero byte enable leaves the word alone
        drive(0, 1'b0, 1'b1, 4'b0000, 32'h40, 32'h1111_1111);
        wait_resp(0, 1'b0, w, d);
        drive(0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        wait_resp(0, 1'b0, w, d);
        check32("be_zero_nochange", d, 32'hDEAD55EF);

        // Out of range write and read, word 0 unchanged
        drive(0, 1'b0, 1'b1, 4'hF, 32'h1000, 32'h1234_5678);
        wait_resp(0, 1'b0, w, d);
        checkn("oor_write_resp", w, 2);
        drive(0, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
        wait_resp(0, 1'b0, w, d);
        check32("oor_read_zero", d, 32'h0);
        drive(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        wait_resp(0, 1'b0, w, d);
        check32("word0_unchanged", d, 32'h0);

        // Read and write together act as a write with zero read data
        drive(0, 1'b1, 1'b1, 4'hF, 32'h44, 32'hAABB_CCDD);
        wait_resp(0, 1'b0, w, d);
        check32("both_rdata_zero", d, 32'h0);
        drive(0, 1'b1, 1'b0, 4'hF, 32'h44, 32'h0);
        wait_resp(0, 1'b0, w, d);
        check32("both_was_write", d, 32'hAABB_CCDD);
        idle(0, 1);

        // LATENCY=4: reads held continuously respond every 5 cycles
        drive(1, 1'b1, 1'b0, 4'hF, BASE1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            wait_resp(1, 1'b0, w, d);
            checkn($sformatf("lat4_spacing_%0d", i), w, 5);
        end
        idle(1, 1);

        // Below-base address is out of range
        drive(1, 1'b0, 1'b1, 4'hF, 32'h80, 32'hCAFE_F00D);
        wait_resp(1, 1'b0, w, d);
        drive(1, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0);
        wait_resp(1, 1'b0, w, d);
        check32("below_base_zero", d, 32'h0);

        // Reset in the second BUSY cycle discards a pending write
        drive(1, 1'b0, 1'b1, 4'hF, BASE1 + 32'h8, 32'h1122_3344);
        wait_resp(1, 1'b0, w, d);
        idle(1, 1);
        drive(1, 1'b0, 1'b1, 4'hF, BASE1 + 32'h8, 32'hFFFF_FFFF);
        @(posedge clk); #1;     // accepted, first BUSY cycle
        @(posedge clk); #1;     // second BUSY cycle
        rst = 1'b1;
        drv_write[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check32("midop_no_resp", {31'b0, resp_w[1]}, 32'h0);
        end
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 4'hF, BASE1 + 32'h8, 32'h0);
        wait_resp(1, 1'b0, w, d);
        checkn("after_rst_latency", w, 5);
        check32("midop_write_dropped", d, 32'h1122_3344);
        idle(1, 1);

        // Randomized traffic on both instances
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 40; n++) begin
                op = int'($urandom_range(0, 9));
                if (op <= 3)
                    drive(k, 1'b1, 1'b0, 4'($urandom_range(0, 15)), rand_addr(k), $urandom);
                else if (op <= 8 && op != 8)
                    drive(k, 1'b0, 1'b1, 4'hF, rand_addr(k), $urandom);
                else if (op == 8)
                    drive(k, 1'b1, 1'b1, 4'($urandom_range(0, 15)), rand_addr(k), $urandom);
                else
                    drive(k, 1'b0, 1'b1, 4'($urandom_range(0, 15)), rand_addr(k), $urandom);
                scr = (k == 1) && ($urandom_range(0, 1) == 1);
                wait_resp(k, scr, w, d);
                checkn($sformatf("rand_latency_dut%0d_%0d", k, n), w, lat_of(k) + 1);
                gap = int'($urandom_range(0, 2));
                if (gap > 0) idle(k, gap);
            end
            idle(k, 1);
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute guard against a stuck run
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
